trigger_deadlock_report_arbiter: RTL

- Collects the per-instance `block` flags from the trigger's HLS deadlock monitors (NUM_MON of them).
- Qualifies each flag by persistence: it must stay high for THRESH consecutive cycles.
- Latches a detection timestamp per monitor.
- Shares a single valid/ready report channel among monitors using round-robin arbitration, so the PS-side debug logger sees one report per deadlock episode.

---
 rtl/trigger_deadlock_report_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/trigger_deadlock_report_arbiter.sv
// Deadlock report arbiter: qualifies per-monitor block flags by persistence,
// timestamps each detection, and serialises reports over one valid/ready
// channel with round-robin selection among pending monitors.
module trigger_deadlock_report_arbiter #(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned THRESH  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_id,
    output logic [31:0]        rpt_cycles,
    output logic [NUM_MON-1:0] pending,
    output logic               deadlock_any
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(THRESH - 1);

    state_e             state_q, state_d;
    logic [31:0]        cyc_q, cyc_d;
    logic [CNT_W-1:0]   cnt_q [NUM_MON];
    logic [CNT_W-1:0]   cnt_d [NUM_MON];
    logic [31:0]        ts_q [NUM_MON];
    logic [31:0]        ts_d [NUM_MON];
    logic [NUM_MON-1:0] armed_q, armed_d;
    logic [NUM_MON-1:0] pending_q, pending_d;
    logic [NUM_MON-1:0] detect;
    logic [NUM_MON-1:0] pend_sh;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    rpt_id_q, rpt_id_d;
    logic [31:0]        rpt_cycles_q, rpt_cycles_d;
    logic               rpt_valid_q, rpt_valid_d;
    logic [ID_W-1:0]    grant;
    logic               grant_vld;
    logic               handshake;

    assign handshake = rpt_valid_q & rpt_ready;

    // Persistence counters, one-shot arming, detection and pending bookkeeping.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        detect = '0;
        armed_d = armed_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_MON; i++) begin
            detect[i] = enable & mon_block[i] & armed_q[i] & (cnt_q[i] == CntMax);
            if (enable && mon_block[i]) begin
                cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end else begin
                cnt_d[i] = '0;
            end
            // Re-arm on any low cycle so each continuous episode reports once.
            if (!mon_block[i]) begin
                armed_d[i] = 1'b1;
            end else if (detect[i]) begin
                armed_d[i] = 1'b0;
            end
            ts_d[i] = detect[i] ? cyc_q : ts_q[i];
            // A fresh detection beats both clear and the handshake retire.
            if (detect[i]) begin
                pending_d[i] = 1'b1;
            end else if (clear) begin
                pending_d[i] = 1'b0;
            end else if (handshake && (rpt_id_q == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Round-robin pick: first pending bit after last_grant, wrapping.
    always_comb begin
        grant = '0;
        grant_vld = 1'b0;
        pend_sh = '0;
        for (int unsigned j = 1; j <= NUM_MON; j++) begin
            pend_sh = pending_q >> ((32'(last_grant_q) + j) % NUM_MON);
            if (!grant_vld && pend_sh[0]) begin
                grant = ID_W'((32'(last_grant_q) + j) % NUM_MON);
                grant_vld = 1'b1;
            end
        end
    end

    // Report FSM: load a granted report, hold it until the handshake.
    always_comb begin
        state_d = state_q;
        rpt_valid_d = rpt_valid_q;
        rpt_id_d = rpt_id_q;
        rpt_cycles_d = rpt_cycles_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    rpt_id_d = grant;
                    rpt_cycles_d = ts_q[grant];
                    rpt_valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (handshake) begin
                    rpt_valid_d = 1'b0;
                    last_grant_d = rpt_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cyc_q <= '0;
            armed_q <= '1;
            pending_q <= '0;
            last_grant_q <= ID_W'(NUM_MON - 1);
            rpt_id_q <= '0;
            rpt_cycles_q <= '0;
            rpt_valid_q <= 1'b0;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt_q[i] <= '0;
                ts_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cyc_q <= cyc_d;
            armed_q <= armed_d;
            pending_q <= pending_d;
            last_grant_q <= last_grant_d;
            rpt_id_q <= rpt_id_d;
            rpt_cycles_q <= rpt_cycles_d;
            rpt_valid_q <= rpt_valid_d;
            for (int i = 0; i < NUM_MON; i++) begin
                cnt_q[i] <= cnt_d[i];
                ts_q[i] <= ts_d[i];
            end
        end
    end

    assign rpt_valid = rpt_valid_q;
    assign rpt_id = rpt_id_q;
    assign rpt_cycles = rpt_cycles_q;
    assign pending = pending_q;
    assign deadlock_any = (|pending_q) | rpt_valid_q;

endmodule
